// File: rtl/uart_rx_basic.sv
// uart_rx_basic: 8N1 UART receiver, LSB first, no parity, mid-bit sampling.
// Ports:
//   clk           - system clock, rising edge
//   rst_n         - asynchronous active-low reset
//   rx            - serial input, idles high, asynchronous to clk
//   data_out[7:0] - last correctly framed byte, held until the next good frame
//   valid         - one-cycle pulse, data_out updated this cycle
//   framing_error - one-cycle pulse, stop bit sampled low
//   busy          - high while a frame (or a post-error break) is in progress
module uart_rx_basic #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;

    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_n;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_n;
    logic [7:0]       r_data;
    logic [7:0]       w_data_n;
    logic             r_valid;
    logic             w_valid_n;
    logic             r_ferr;
    logic             w_ferr_n;
    logic             r_busy;
    logic             w_busy_n;

    logic             w_half_done;
    logic             w_bit_done;

    // Two-flop synchronizer; reset to 1 so the line reads idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s      = r_sync2;
    assign w_half_done = (r_cnt == CNT_W'(HALF_BIT - 1));
    assign w_bit_done  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_bit_idx <= w_bit_idx_n;
            r_shift   <= w_shift_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_ferr    <= w_ferr_n;
            r_busy    <= w_busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_bit_idx_n = r_bit_idx;
        w_shift_n   = r_shift;
        w_data_n    = r_data;
        w_valid_n   = 1'b0;
        w_ferr_n    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_n = S_START;
                    w_cnt_n   = '0;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (w_half_done) begin
                    w_cnt_n = '0;
                    if (!w_rx_s) begin
                        w_bit_idx_n = '0;
                        w_state_n   = S_DATA;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_n              = '0;
                    w_shift_n[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leave mid stop bit so an immediately following start edge is seen.
                if (w_bit_done) begin
                    w_cnt_n = '0;
                    if (w_rx_s) begin
                        w_data_n  = r_shift;
                        w_valid_n = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_ferr_n  = 1'b1;
                        w_state_n = S_BREAK;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line recovers so a break is not decoded as frames.
                if (w_rx_s) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase

        w_busy_n = (w_state_n != S_IDLE);
    end

    assign data_out      = r_data;
    assign valid         = r_valid;
    assign framing_error = r_ferr;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_basic.sv
`timescale 1ns/1ps
// tb_uart_rx_basic: table-driven frames plus hand-written corner sequences,
// received bytes checked against a scoreboard queue.
module tb_uart_rx_basic;

    localparam int unsigned CLK_FREQ  = 50000000;
    localparam int unsigned BAUD_RATE = 250000;
    localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;   // 200 cycles
    localparam int unsigned HALF      = CPB / 2;                // 100 cycles
    localparam int unsigned BIT_NS    = CPB * 20;               // 4000 ns
    localparam int unsigned BIT_FAST  = BIT_NS * 98 / 100;      // -2% period
    localparam int unsigned BIT_SLOW  = BIT_NS * 102 / 100;     // +2% period

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       framing_error;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_ferr  = 0;

    logic [7:0] sb[$];
    logic [7:0] last_good;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_basic #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data_out     (data_out),
        .valid        (valid),
        .framing_error(framing_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-banged 8N1 transmitter; leaves rx at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    task automatic push_exp(input logic [7:0] b);
        sb.push_back(b);
        last_good = b;
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            check("valid_ferr_exclusive", 32'(framing_error), 32'd0);
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [7:0] e;
                e = sb.pop_front();
                check("rx_byte", 32'(data_out), 32'(e));
            end
        end
        if (framing_error) n_ferr++;
    end

    initial begin
        int v0;
        int f0;
        logic [7:0] hello[5];

        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hAA, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hC3, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b0};
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C;
        hello[3] = 8'h6C; hello[4] = 8'h6F;

        last_good = 8'h00;
        rx    = 1'b1;
        rst_n = 1'b0;
        #95;
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_ferr", 32'(framing_error), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        #5;
        rst_n = 1'b1;
        #(BIT_NS);

        // Table of single frames.
        for (int k = 0; k < 6; k++) begin
            v0 = n_valid;
            f0 = n_ferr;
            if (vecs[k].exp_valid) push_exp(vecs[k].data);
            send_byte(vecs[k].data, vecs[k].stop, BIT_NS);
            rx = 1'b1;
            #(BIT_NS);
            check("vec_valid_count", 32'(n_valid - v0), 32'(vecs[k].exp_valid));
            check("vec_ferr_count", 32'(n_ferr - f0), 32'(vecs[k].exp_ferr));
            check("vec_data_out", 32'(data_out), 32'(last_good));
            check("vec_busy_idle", 32'(busy), 32'd0);
        end

        // Short low glitch is rejected at mid start bit.
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        #100;
        check("glitch_busy_high", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (HALF + 3) @(posedge clk);
        #1;
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        check("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);
        #(BIT_NS);

        // Bad stop bit followed by a long break, then a clean frame.
        v0 = n_valid;
        f0 = n_ferr;
        send_byte(8'hA5, 1'b0, BIT_NS);
        for (int p = 0; p < 20; p++) begin
            #(BIT_NS);
            if (p == 10) begin
                check("break_data_hold", 32'(data_out), 32'(last_good));
                check("break_busy", 32'(busy), 32'd1);
            end
        end
        check("break_ferr_once", 32'(n_ferr - f0), 32'd1);
        check("break_no_valid", 32'(n_valid - v0), 32'd0);
        rx = 1'b1;
        #(BIT_NS);
        check("break_recovered", 32'(busy), 32'd0);
        push_exp(8'h3C);
        send_byte(8'h3C, 1'b1, BIT_NS);
        #(BIT_NS);
        check("after_break_valid", 32'(n_valid - v0), 32'd1);
        check("after_break_data", 32'(data_out), 32'h3C);

        // "Hello" back-to-back at +2% and -2% bit period.
        for (int r = 0; r < 2; r++) begin
            v0 = n_valid;
            f0 = n_ferr;
            for (int c = 0; c < 5; c++) begin
                push_exp(hello[c]);
                send_byte(hello[c], 1'b1, (r == 0) ? BIT_SLOW : BIT_FAST);
            end
            #(BIT_NS);
            check("hello_valid_count", 32'(n_valid - v0), 32'd5);
            check("hello_no_ferr", 32'(n_ferr - f0), 32'd0);
        end

        // Reset asserted during data bit 3 of 0xF0.
        v0 = n_valid;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b0;
            #(BIT_NS);
        end
        rx = 1'b0;
        #(BIT_NS / 2);
        rst_n = 1'b0;
        #(BIT_NS / 2);
        check("midrst_data_out", 32'(data_out), 32'h00);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_ferr", 32'(framing_error), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        #(BIT_NS / 2);
        rst_n = 1'b1;
        #(BIT_NS / 2);
        #(BIT_NS * 4);
        #(BIT_NS);
        check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        push_exp(8'h81);
        send_byte(8'h81, 1'b1, BIT_NS);
        #(BIT_NS);
        check("post_rst_valid", 32'(n_valid - v0), 32'd1);
        check("post_rst_data", 32'(data_out), 32'h81);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
